// File: rtl/jtopl_snd_fifo.sv
// Sample FIFO behind the jtopl accumulator: captures each new `snd` value and serves it over valid/ready.
// Optional DC-blocking high-pass filter ahead of the FIFO, enabled with `define JTOPL_SNDFIFO_DCBLOCK_EN.
module jtopl_snd_fifo #(
  parameter int W   = 13,
  parameter int AW  = 3,
  parameter int DCK = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cenop,
  input  logic                zero,
  input  logic signed [W-1:0] snd,
  input  logic                clr_ovf,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [AW:0]         level,
  output logic                ovf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic                r_cap;
  logic        [W-1:0] r_mem [DEPTH];
  logic        [AW:0]  r_wr;
  logic        [AW:0]  r_rd;
  logic        [AW:0]  r_level;
  logic        [W-1:0] r_dout;
  logic                r_valid;
  logic                r_ovf;

  logic        [W-1:0] w_wdata;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic        [AW:0]  w_wr_nx;
  logic        [AW:0]  w_rd_nx;
  logic        [AW:0]  w_lvl_nx;
  logic        [W-1:0] w_head;

`ifdef JTOPL_SNDFIFO_DCBLOCK_EN
  localparam int WI = W + DCK + 2;

  logic signed [WI-1:0] r_x1;
  logic signed [WI-1:0] r_y1;
  logic signed [WI-1:0] w_x;
  logic signed [WI-1:0] w_y;

  // Clamp the wide filter result into W bits instead of letting it wrap.
  function automatic logic [W-1:0] sat_w(input logic signed [WI-1:0] v);
    logic [WI-W:0] top;
    top = v[WI-1:W-1];
    if ((&top) || !(|top)) begin
      sat_w = v[W-1:0];
    end else begin
      sat_w = {v[WI-1], {(W-1){~v[WI-1]}}};
    end
  endfunction

  // High-pass filter: y = x - x1 + y1 - (y1 >>> DCK).
  always_comb begin
    w_x     = WI'(snd);
    w_y     = w_x - r_x1 + r_y1 - (r_y1 >>> DCK);
    w_wdata = sat_w(w_y);
  end

  // Filter history advances on every capture, including dropped ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1 <= {WI{1'b0}};
      r_y1 <= {WI{1'b0}};
    end else if (r_cap) begin
      r_x1 <= w_x;
      r_y1 <= w_y;
    end
  end
`else
  assign w_wdata = snd;
`endif

  // Handshake decode and next-state pointers; head is bypassed when the write lands at the new read slot.
  always_comb begin
    w_full   = (r_level == DEPTH_L);
    w_pop    = r_valid & dout_ready;
    w_push   = r_cap & (~w_full | w_pop);
    w_drop   = r_cap & w_full & ~w_pop;
    w_wr_nx  = w_push ? (r_wr + ONE_L) : r_wr;
    w_rd_nx  = w_pop  ? (r_rd + ONE_L) : r_rd;
    w_lvl_nx = w_wr_nx - w_rd_nx;
    if (w_push && (r_wr[AW-1:0] == w_rd_nx[AW-1:0])) begin
      w_head = w_wdata;
    end else begin
      w_head = r_mem[w_rd_nx[AW-1:0]];
    end
  end

  // Capture strobe: snd is valid one clock after the cenop&zero edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap <= 1'b0;
    end else begin
      r_cap <= cenop & zero;
    end
  end

  // Storage array; a capture pending across reset is not written.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr[AW-1:0]] <= w_wdata;
    end
  end

  // Pointers, level, show-ahead output and sticky overflow (set wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= {(AW+1){1'b0}};
      r_rd    <= {(AW+1){1'b0}};
      r_level <= {(AW+1){1'b0}};
      r_valid <= 1'b0;
      r_dout  <= {W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_wr    <= w_wr_nx;
      r_rd    <= w_rd_nx;
      r_level <= w_lvl_nx;
      r_valid <= (w_lvl_nx != {(AW+1){1'b0}});
      r_dout  <= (w_lvl_nx != {(AW+1){1'b0}}) ? w_head : {W{1'b0}};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign level      = r_level;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_jtopl_snd_fifo.sv
// Scoreboard bench for jtopl_snd_fifo: captures queue expected samples, a negedge monitor checks pops.
module tb_jtopl_snd_fifo;

  logic               clk = 1'b0;
  logic               rst;
  logic               cenop;
  logic               zero;
  logic signed [12:0] snd;
  logic               clr_ovf;
  logic signed [12:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic        [3:0]  level;
  logic               ovf;

  int n_vec = 0;
  int n_err = 0;
  logic signed [12:0] q[$];

  jtopl_snd_fifo #(.W(13), .AW(3), .DCK(8)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .snd(snd),
    .clr_ovf(clr_ovf), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected no data", dout);
      end else begin
        chk("pop_data", dout, q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic signed [12:0] v, input bit keep);
    snd   = v;
    cenop = 1'b1;
    zero  = 1'b1;
    if (keep) q.push_back(v);
    tick();
    cenop = 1'b0;
    zero  = 1'b0;
    tick();
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    dout_ready = 1'b1;
    while (dout_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    dout_ready = 1'b0;
    chk("drain_bounded", cnt < 40, 1);
    chk("drain_level0", level, 0);
    chk("drain_valid0", dout_valid, 0);
    chk("drain_dout0", dout, 0);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cenop = 1'b0; zero = 1'b0; snd = 13'sd0;
    clr_ovf = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);

    // Capture timing: valid 2 clk after the edge; held cenop gives no extra push.
    snd = 13'sh0123; cenop = 1'b1; zero = 1'b1;
    q.push_back(13'sh0123);
    tick();
    zero = 1'b0;
    chk("cap_valid_early", dout_valid, 0);
    tick();
    chk("cap_valid", dout_valid, 1);
    chk("cap_dout", dout, 32'h0123);
    chk("cap_level", level, 1);
    repeat (4) tick();
    chk("cap_hold_level", level, 1);
    cenop = 1'b0;
    drain();

    // Order and drain.
    capture(-13'sd5, 1'b1);
    capture(13'sd7, 1'b1);
    capture(13'sd4095, 1'b1);
    chk("ord_level", level, 3);
    drain();

    // Overflow: ninth sample dropped.
    for (int i = 1; i <= 9; i++) capture(13'(i), i <= 8);
    chk("ovf_level", level, 8);
    chk("ovf_set", ovf, 1);
    drain();
    chk("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) capture(13'(i), 1'b1);
    snd = 13'sd100; cenop = 1'b1; zero = 1'b1;
    q.push_back(13'sd100);
    tick();
    cenop = 1'b0; zero = 1'b0; dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("full_pp_level", level, 8);
    chk("full_pp_ovf", ovf, 0);
    chk("full_pp_head", dout, 2);
    // Drop coincident with clr_ovf: set wins.
    snd = 13'sd200; cenop = 1'b1; zero = 1'b1;
    tick();
    cenop = 1'b0; zero = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("drop_clr_ovf", ovf, 1);
    chk("drop_level", level, 8);
    drain();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

    // Reset mid-stream with a capture pending.
    for (int i = 0; i < 5; i++) capture(13'(50 + i), 1'b0);
    chk("pre_rst_level", level, 5);
    snd = 13'sh0555; cenop = 1'b1; zero = 1'b1;
    tick();
    cenop = 1'b0; zero = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_level", level, 0);
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_ovf", ovf, 0);
    tick(); tick();
    chk("mrst_no_pending", level, 0);
    capture(13'sh0AAA, 1'b1);
    chk("post_rst_level", level, 1);
    chk("post_rst_dout", dout, 32'h0AAA);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
